// File: rtl/core_pkg.sv
// Shared core types and widths used by the commit/retire slice.
package core_pkg;

    localparam int ISSUE_WIDTH = 2;
    localparam int ROB_ENTRIES = 32;
    localparam int IDX_W       = $clog2(ROB_ENTRIES);
    localparam int PREG_W      = 7;

    // Architectural register 31 is the zero register and never owns a mapping.
    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef logic [PREG_W-1:0] preg_tag_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RECOVER  = 2'd1,
        REDIRECT = 2'd2
    } retire_state_e;

endpackage

// File: rtl/commit_retire_unit_if.sv
// Registered 2-wide commit stream from the ROB into the retire unit.
interface commit_retire_unit_if
    import core_pkg::*;
();
    logic [ISSUE_WIDTH-1:0]            valid;
    logic [ISSUE_WIDTH-1:0][4:0]       arch_rd;
    preg_tag_t [ISSUE_WIDTH-1:0]       phys_rd;
    logic [ISSUE_WIDTH-1:0]            exception;
    logic [ISSUE_WIDTH-1:0][IDX_W-1:0] rob_idx;
    logic [ISSUE_WIDTH-1:0]            is_store;
    logic [ISSUE_WIDTH-1:0]            is_branch;
    logic [ISSUE_WIDTH-1:0][31:0]      pc;
    logic [ISSUE_WIDTH-1:0]            br_taken;
    logic [ISSUE_WIDTH-1:0]            br_call;
    logic [ISSUE_WIDTH-1:0]            br_ret;
    logic [ISSUE_WIDTH-1:0][31:0]      br_target;

    modport master (
        output valid, arch_rd, phys_rd, exception, rob_idx, is_store, is_branch,
               pc, br_taken, br_call, br_ret, br_target
    );

    modport slave (
        input  valid, arch_rd, phys_rd, exception, rob_idx, is_store, is_branch,
               pc, br_taken, br_call, br_ret, br_target
    );
endinterface

// File: rtl/arch_rat_table.sv
// Architectural RAT: 32 entries, two write ports (slot1 wins on the same
// entry) and two read ports. Read port 1 sees slot0's same-cycle write so a
// younger slot frees the tag an older slot just installed.
module arch_rat_table
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      we,
    input  logic [1:0][4:0] waddr,
    input  preg_tag_t [1:0] wdata,
    input  logic [1:0][4:0] raddr,
    output preg_tag_t [1:0] rdata,
    output preg_tag_t [31:0] rat
);
    preg_tag_t rat_reg [32];

    // Identity map at reset (XZR maps to 0); slot1 write issued last so it wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 32; r++) begin
                rat_reg[r] <= (r < 31) ? preg_tag_t'(r) : '0;
            end
        end else begin
            if (we[0]) rat_reg[waddr[0]] <= wdata[0];
            if (we[1]) rat_reg[waddr[1]] <= wdata[1];
        end
    end

    assign rdata[0] = rat_reg[raddr[0]];
    assign rdata[1] = (we[0] && (waddr[0] == raddr[1])) ? wdata[0] : rat_reg[raddr[1]];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rat_out
            assign rat[gi] = rat_reg[gi];
        end
    endgenerate
endmodule

// File: rtl/commit_retire_unit.sv
// Commit/retire unit: updates the architectural RAT, frees superseded tags,
// releases stores, trains the predictor and sequences exception recovery
// (flush -> RAT restore -> fetch redirect). All outputs are registered.
// Optional macro RETIRE_PERF_CNT_EN adds saturating 64-bit retire/exception counters.
module commit_retire_unit
    import core_pkg::*;
#(
    parameter int          RECOVER_CYC = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0100
) (
    input  logic                        clk,
    input  logic                        reset_n,
    commit_retire_unit_if.slave         cm,
    output logic [ISSUE_WIDTH-1:0]      free_en,
    output preg_tag_t [ISSUE_WIDTH-1:0] free_tag,
    output logic [ISSUE_WIDTH-1:0]      st_commit_en,
    output logic [ISSUE_WIDTH-1:0][IDX_W-1:0] st_commit_idx,
    output logic [ISSUE_WIDTH-1:0]      bp_upd_en,
    output logic [ISSUE_WIDTH-1:0][31:0] bp_upd_pc,
    output logic [ISSUE_WIDTH-1:0][31:0] bp_upd_target,
    output logic [ISSUE_WIDTH-1:0]      bp_upd_taken,
    output logic [ISSUE_WIDTH-1:0]      bp_upd_call,
    output logic [ISSUE_WIDTH-1:0]      bp_upd_ret,
    output logic                        flush_en,
    output logic [IDX_W-1:0]            flush_ptr,
    output logic                        rat_restore_en,
    output preg_tag_t [31:0]            arch_rat,
    output logic                        redirect_en,
    output logic [31:0]                 redirect_pc,
    output logic [31:0]                 exc_pc,
`ifdef RETIRE_PERF_CNT_EN
    output logic [63:0]                 perf_retired,
    output logic [63:0]                 perf_exceptions,
`endif
    output logic                        busy
);
    localparam int ISSUE_W = ISSUE_WIDTH;
    localparam int CNT_W   = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

    retire_state_e     state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ISSUE_W-1:0] retire_ok, exc_hit, rat_we, st_fire, bp_fire;
    logic              blocked, exc_any;
    logic [IDX_W-1:0]  exc_idx;
    logic [31:0]       exc_pc_sel;
    preg_tag_t [ISSUE_W-1:0] old_tag;

    // Slot qualification: older slots retire, the first excepting slot and all younger ones are squashed.
    always_comb begin
        retire_ok  = '0;
        exc_hit    = '0;
        blocked    = 1'b0;
        exc_idx    = cm.rob_idx[0];
        exc_pc_sel = cm.pc[0];
        for (int k = 0; k < ISSUE_W; k++) begin
            if ((state_reg == RUN) && cm.valid[k] && !blocked) begin
                if (cm.exception[k]) begin
                    exc_hit[k] = 1'b1;
                    blocked    = 1'b1;
                    exc_idx    = cm.rob_idx[k];
                    exc_pc_sel = cm.pc[k];
                end else begin
                    retire_ok[k] = 1'b1;
                end
            end
        end
        exc_any = |exc_hit;
    end

    generate
        for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_slot
            assign rat_we[gi]  = retire_ok[gi] && (cm.arch_rd[gi] != XZR_IDX);
            assign st_fire[gi] = retire_ok[gi] && cm.is_store[gi];
            assign bp_fire[gi] = retire_ok[gi] && cm.is_branch[gi];
        end
    endgenerate

    arch_rat_table u_rat (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (rat_we),
        .waddr   (cm.arch_rd),
        .wdata   (cm.phys_rd),
        .raddr   (cm.arch_rd),
        .rdata   (old_tag),
        .rat     (arch_rat)
    );

    // Recovery sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: RECOVER is held RECOVER_CYC cycles, REDIRECT exactly one.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RUN: begin
                if (exc_any) begin
                    state_next = RECOVER;
                    cnt_next   = '0;
                end
            end
            RECOVER: begin
                if (cnt_reg == CNT_W'(RECOVER_CYC - 1)) state_next = REDIRECT;
                else                                    cnt_next   = cnt_reg + 1'b1;
            end
            REDIRECT: state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    // Per-slot retire effects, registered one cycle after the commit sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            free_en       <= '0;
            free_tag      <= '0;
            st_commit_en  <= '0;
            st_commit_idx <= '0;
            bp_upd_en     <= '0;
            bp_upd_pc     <= '0;
            bp_upd_target <= '0;
            bp_upd_taken  <= '0;
            bp_upd_call   <= '0;
            bp_upd_ret    <= '0;
        end else begin
            for (int k = 0; k < ISSUE_W; k++) begin
                free_en[k]       <= rat_we[k];
                free_tag[k]      <= rat_we[k] ? old_tag[k] : '0;
                st_commit_en[k]  <= st_fire[k];
                st_commit_idx[k] <= st_fire[k] ? cm.rob_idx[k] : '0;
                bp_upd_en[k]     <= bp_fire[k];
                bp_upd_pc[k]     <= bp_fire[k] ? cm.pc[k] : '0;
                bp_upd_target[k] <= bp_fire[k] ? cm.br_target[k] : '0;
                bp_upd_taken[k]  <= bp_fire[k] & cm.br_taken[k];
                bp_upd_call[k]   <= bp_fire[k] & cm.br_call[k];
                bp_upd_ret[k]    <= bp_fire[k] & cm.br_ret[k];
            end
        end
    end

    // Flush/recovery/redirect status; flush_ptr and exc_pc hold the last exception.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_en       <= 1'b0;
            flush_ptr      <= '0;
            exc_pc         <= '0;
            rat_restore_en <= 1'b0;
            redirect_en    <= 1'b0;
            redirect_pc    <= '0;
            busy           <= 1'b0;
        end else begin
            flush_en       <= exc_any;
            if (exc_any) begin
                flush_ptr <= exc_idx;
                exc_pc    <= exc_pc_sel;
            end
            rat_restore_en <= (state_next == RECOVER);
            redirect_en    <= (state_next == REDIRECT);
            redirect_pc    <= (state_next == REDIRECT) ? EXC_VECTOR : '0;
            busy           <= (state_next != RUN);
        end
    end

`ifdef RETIRE_PERF_CNT_EN
    logic [64:0] retired_sum, exc_sum;

    // Candidate counter values with a carry bit to detect saturation.
    always_comb begin
        retired_sum = {1'b0, perf_retired};
        for (int k = 0; k < ISSUE_W; k++) begin
            retired_sum = retired_sum + 65'(retire_ok[k]);
        end
        exc_sum = {1'b0, perf_exceptions} + 65'(exc_any);
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_retired    <= '0;
            perf_exceptions <= '0;
        end else begin
            perf_retired    <= retired_sum[64] ? '1 : retired_sum[63:0];
            perf_exceptions <= exc_sum[64]     ? '1 : exc_sum[63:0];
        end
    end
`endif

    // Commit slots must fill from slot0; a lone slot1 is an upstream bug.
    assert property (@(posedge clk) disable iff (!reset_n)
        !(cm.valid[1] && !cm.valid[0]));

endmodule

// File: tb/tb_commit_retire_unit.sv
// Bench for commit_retire_unit: directed scenarios plus random commit traffic
// compared every cycle against a sequential reference model.
module tb_commit_retire_unit;
    import core_pkg::*;

    localparam int RC = 2;

    logic clk;
    logic reset_n;

    commit_retire_unit_if cm ();

    logic [1:0]           free_en;
    preg_tag_t [1:0]      free_tag;
    logic [1:0]           st_commit_en;
    logic [1:0][IDX_W-1:0] st_commit_idx;
    logic [1:0]           bp_upd_en;
    logic [1:0][31:0]     bp_upd_pc;
    logic [1:0][31:0]     bp_upd_target;
    logic [1:0]           bp_upd_taken, bp_upd_call, bp_upd_ret;
    logic                 flush_en;
    logic [IDX_W-1:0]     flush_ptr;
    logic                 rat_restore_en;
    preg_tag_t [31:0]     arch_rat;
    logic                 redirect_en;
    logic [31:0]          redirect_pc;
    logic [31:0]          exc_pc;
    logic                 busy;
`ifdef RETIRE_PERF_CNT_EN
    logic [63:0]          perf_retired, perf_exceptions;
`endif

    commit_retire_unit #(.RECOVER_CYC(RC), .EXC_VECTOR(32'h0000_0100)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cm             (cm.slave),
        .free_en        (free_en),
        .free_tag       (free_tag),
        .st_commit_en   (st_commit_en),
        .st_commit_idx  (st_commit_idx),
        .bp_upd_en      (bp_upd_en),
        .bp_upd_pc      (bp_upd_pc),
        .bp_upd_target  (bp_upd_target),
        .bp_upd_taken   (bp_upd_taken),
        .bp_upd_call    (bp_upd_call),
        .bp_upd_ret     (bp_upd_ret),
        .flush_en       (flush_en),
        .flush_ptr      (flush_ptr),
        .rat_restore_en (rat_restore_en),
        .arch_rat       (arch_rat),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .exc_pc         (exc_pc),
`ifdef RETIRE_PERF_CNT_EN
        .perf_retired   (perf_retired),
        .perf_exceptions(perf_exceptions),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_rat [32];
    int          m_since;        // 0 = running, else cycles since the exception edge
    logic [1:0]  e_free_en, e_st_en, e_bp_en, e_taken, e_call, e_ret;
    logic [6:0]  e_free_tag [2];
    logic [4:0]  e_st_idx [2];
    logic [31:0] e_bp_pc [2], e_bp_tgt [2];
    logic        e_flush, e_restore, e_redirect, e_busy;
    logic [4:0]  e_flush_ptr;
    logic [31:0] e_exc_pc;

    task automatic chk(string nm, logic [223:0] act, logic [223:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_rat[r] = (r < 31) ? r : 0;
        m_since = 0;
        e_free_en = '0; e_st_en = '0; e_bp_en = '0;
        e_taken = '0; e_call = '0; e_ret = '0;
        e_flush = 1'b0; e_restore = 1'b0; e_redirect = 1'b0; e_busy = 1'b0;
        e_flush_ptr = '0; e_exc_pc = '0;
    endtask

    // Predict outputs after the coming edge from the inputs now applied.
    task automatic model_edge();
        bit stop;
        e_free_en = '0; e_st_en = '0; e_bp_en = '0;
        e_flush = 1'b0;
        if (m_since == 0) begin
            stop = 0;
            for (int k = 0; k < 2; k++) begin
                if (cm.valid[k] && !stop) begin
                    if (cm.exception[k]) begin
                        stop        = 1;
                        e_flush     = 1'b1;
                        e_flush_ptr = cm.rob_idx[k];
                        e_exc_pc    = cm.pc[k];
                    end else begin
                        if (cm.arch_rd[k] != 5'd31) begin
                            e_free_en[k]  = 1'b1;
                            e_free_tag[k] = 7'(m_rat[cm.arch_rd[k]]);
                            m_rat[cm.arch_rd[k]] = int'(cm.phys_rd[k]);
                        end
                        if (cm.is_store[k]) begin
                            e_st_en[k]  = 1'b1;
                            e_st_idx[k] = cm.rob_idx[k];
                        end
                        if (cm.is_branch[k]) begin
                            e_bp_en[k]  = 1'b1;
                            e_bp_pc[k]  = cm.pc[k];
                            e_bp_tgt[k] = cm.br_target[k];
                            e_taken[k]  = cm.br_taken[k];
                            e_call[k]   = cm.br_call[k];
                            e_ret[k]    = cm.br_ret[k];
                        end
                    end
                end
            end
            if (stop) m_since = 1;
        end else begin
            m_since++;
            if (m_since > RC + 1) m_since = 0;
        end
        e_busy     = (m_since != 0);
        e_restore  = (m_since >= 1) && (m_since <= RC);
        e_redirect = (m_since == RC + 1);
    endtask

    task automatic compare_all();
        logic [223:0] er;
        chk("free_en", free_en, e_free_en);
        chk("st_commit_en", st_commit_en, e_st_en);
        chk("bp_upd_en", bp_upd_en, e_bp_en);
        for (int k = 0; k < 2; k++) begin
            if (e_free_en[k]) chk($sformatf("free_tag[%0d]", k), free_tag[k], e_free_tag[k]);
            if (e_st_en[k])   chk($sformatf("st_commit_idx[%0d]", k), st_commit_idx[k], e_st_idx[k]);
            if (e_bp_en[k]) begin
                chk($sformatf("bp_upd_pc[%0d]", k), bp_upd_pc[k], e_bp_pc[k]);
                chk($sformatf("bp_upd_target[%0d]", k), bp_upd_target[k], e_bp_tgt[k]);
                chk($sformatf("bp_upd_flags[%0d]", k),
                    {bp_upd_taken[k], bp_upd_call[k], bp_upd_ret[k]},
                    {e_taken[k], e_call[k], e_ret[k]});
            end
        end
        chk("flush_en", flush_en, e_flush);
        chk("flush_ptr", flush_ptr, e_flush_ptr);
        chk("exc_pc", exc_pc, e_exc_pc);
        chk("rat_restore_en", rat_restore_en, e_restore);
        chk("redirect_en", redirect_en, e_redirect);
        if (e_redirect) chk("redirect_pc", redirect_pc, 32'h0000_0100);
        chk("busy", busy, e_busy);
        er = '0;
        for (int r = 0; r < 32; r++) er[r*7 +: 7] = 7'(m_rat[r]);
        chk("arch_rat", arch_rat, er);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        cm.valid = '0; cm.arch_rd = '0; cm.phys_rd = '0; cm.exception = '0;
        cm.rob_idx = '0; cm.is_store = '0; cm.is_branch = '0; cm.pc = '0;
        cm.br_taken = '0; cm.br_call = '0; cm.br_ret = '0; cm.br_target = '0;
    endtask

    task automatic set_slot(int k, int rd, int p);
        cm.valid[k]   = 1'b1;
        cm.arch_rd[k] = 5'(rd);
        cm.phys_rd[k] = 7'(p);
    endtask

    task automatic rand_inputs();
        int sel;
        clear_inputs();
        sel = $urandom_range(0, 3);
        cm.valid = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
        for (int k = 0; k < 2; k++) begin
            sel = $urandom_range(0, 9);
            cm.arch_rd[k]   = (sel == 0) ? 5'd31 : (sel < 5) ? 5'($urandom_range(0, 3))
                                                             : 5'($urandom_range(0, 30));
            cm.phys_rd[k]   = 7'($urandom);
            cm.exception[k] = ($urandom_range(0, 15) == 0);
            cm.rob_idx[k]   = 5'($urandom);
            cm.is_store[k]  = 1'($urandom);
            cm.is_branch[k] = 1'($urandom);
            cm.pc[k]        = $urandom;
            cm.br_target[k] = $urandom;
            cm.br_taken[k]  = 1'($urandom);
            cm.br_call[k]   = 1'($urandom);
            cm.br_ret[k]    = 1'($urandom);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        compare_all();

        // 1: reset state
        chk("t1_rat5", arch_rat[5], 5);
        chk("t1_enables", {free_en, st_commit_en, bp_upd_en, flush_en, rat_restore_en, redirect_en}, 0);
        chk("t1_busy", busy, 0);

        // 2: two independent renames
        clear_inputs(); set_slot(0, 3, 40); set_slot(1, 7, 41); step();
        chk("t2_free_en", free_en, 2'b11);
        chk("t2_free_tag0", free_tag[0], 3);
        chk("t2_free_tag1", free_tag[1], 7);
        chk("t2_rat3", arch_rat[3], 40);
        chk("t2_rat7", arch_rat[7], 41);

        // 3: same arch reg in both slots
        clear_inputs(); set_slot(0, 4, 42); set_slot(1, 4, 43); step();
        chk("t3_free_tag0", free_tag[0], 4);
        chk("t3_free_tag1", free_tag[1], 42);
        chk("t3_rat4", arch_rat[4], 43);

        // 4: XZR store
        clear_inputs(); set_slot(0, 31, 44); cm.is_store[0] = 1'b1; cm.rob_idx[0] = 5'd9; step();
        chk("t4_free_en", free_en, 2'b00);
        chk("t4_st_en", st_commit_en, 2'b01);
        chk("t4_st_idx0", st_commit_idx[0], 9);
        chk("t4_rat31", arch_rat[31], 0);

        // 5: exception in slot1 and the full recovery sequence
        clear_inputs(); set_slot(0, 2, 45); set_slot(1, 9, 46);
        cm.exception[1] = 1'b1; cm.rob_idx[1] = 5'd12; cm.pc[1] = 32'h80; step();
        chk("t5_free_en", free_en, 2'b01);
        chk("t5_flush", flush_en, 1);
        chk("t5_flush_ptr", flush_ptr, 12);
        chk("t5_exc_pc", exc_pc, 32'h80);
        chk("t5_rat9", arch_rat[9], 9);
        clear_inputs(); step();
        chk("t5_flush_drop", flush_en, 0);
        chk("t5_restore2", rat_restore_en, 1);
        step();
        chk("t5_redirect", redirect_en, 1);
        chk("t5_redirect_pc", redirect_pc, 32'h100);
        chk("t5_restore_off", rat_restore_en, 0);
        step();
        chk("t5_busy_off", busy, 0);

        // 6: reset during RECOVER
        clear_inputs(); set_slot(0, 6, 50); cm.exception[0] = 1'b1; cm.rob_idx[0] = 5'd3; step();
        clear_inputs();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("t6_busy_async", busy, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        compare_all();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_redirect", redirect_en, 0);
        end
        chk("t6_rat6", arch_rat[6], 6);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
